// File: rtl/pe_ifmap_spad_pkg.sv
// Shared definitions for the per-PE ifmap scratchpad: word/spad geometry and FSM states.
package pe_ifmap_spad_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = ADDR_W + 1;  // holds 0..DEPTH inclusive

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL       = 2'd1,
    READY      = 2'd2,
    SLIDE_FILL = 2'd3
  } spad_state_e;
endpackage

// File: rtl/pe_ifmap_spad_ram.sv
// DEPTH x DATA_W scratchpad storage: synchronous write, registered read (1-cycle latency).
module pe_ifmap_spad_ram
  import pe_ifmap_spad_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so the visible output is 0 out of reset; array is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pe_ifmap_spad.sv
// Per-PE ifmap scratchpad: captures one S*q filter-row window, replays it to the MAC,
// and on each stride-1 slide drops the oldest q words and refills only q new ones.
module pe_ifmap_spad
  import pe_ifmap_spad_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [4:0]        S,
  input  logic [4:0]        q,
  input  logic [DATA_W-1:0] ifmap_in,
  input  logic              in_valid,
  input  logic              slide,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              window_ready,
  output logic              cfg_err,
  output logic              ovf
);

  spad_state_e       state, state_nxt;
  logic [4:0]        q_lat;
  logic [CNT_W-1:0]  n_lat;
  logic [ADDR_W-1:0] head, tail, off;
  logic [CNT_W-1:0]  cnt;
  logic              en_q;

  logic [9:0] n_new;
  logic       cfg_bad, en_rise;
  logic       wr_fire, rd_fire, slide_fire, win_done, off_last, ovf_set;

  assign n_new      = {5'd0, S} * {5'd0, q};
  assign cfg_bad    = (n_new == 10'd0) || (n_new > 10'(DEPTH));
  assign en_rise    = en && !en_q;
  assign wr_fire    = en && in_valid && (state == FILL || state == SLIDE_FILL);
  assign slide_fire = en && slide && (state == READY);
  // slide has priority over a coincident read request
  assign rd_fire    = en && rd_req && !slide && (state == READY);
  assign win_done   = wr_fire && ((cnt + 1'b1) == n_lat);
  assign off_last   = ({1'b0, off} == (n_lat - 1'b1));
  assign ovf_set    = en && in_valid && (state == IDLE || state == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:             if (!cfg_bad)  state_nxt = FILL;
        FILL, SLIDE_FILL: if (win_done)  state_nxt = READY;
        READY:            if (slide)     state_nxt = SLIDE_FILL;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_lat        <= '0;
      n_lat        <= '0;
      head         <= '0;
      tail         <= '0;
      off          <= '0;
      cnt          <= '0;
      en_q         <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      window_ready <= 1'b0;
      cfg_err      <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      en_q         <= en;
      rd_valid     <= rd_fire;
      rd_last      <= rd_fire && off_last;
      window_ready <= en && (state_nxt == READY);
      cfg_err      <= (cfg_err && !en_rise) || (en && state == IDLE && cfg_bad);
      ovf          <= (ovf && !en_rise) || ovf_set;

      if (!en) begin
        head <= '0;
        tail <= '0;
        off  <= '0;
        cnt  <= '0;
      end else if (state == IDLE) begin
        q_lat <= q;
        n_lat <= n_new[CNT_W-1:0];
        head  <= '0;
        tail  <= '0;
        off   <= '0;
        cnt   <= '0;
      end else if (wr_fire) begin
        tail <= tail + 1'b1;
        cnt  <= cnt + 1'b1;
      end else if (slide_fire) begin
        head <= head + q_lat;
        cnt  <= cnt - {1'b0, q_lat};
        off  <= '0;
      end else if (rd_fire) begin
        off <= off_last ? '0 : off + 1'b1;
      end
    end
  end

  pe_ifmap_spad_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_fire),
    .waddr (tail),
    .wdata (ifmap_in),
    .re    (rd_fire),
    .raddr (head + off),
    .rdata (rd_data)
  );

endmodule
